// File: rtl/mem_access_ctrl.sv
// Two-client (fetch / load-store) arbiter and sequencer for the word-addressed Memory block.
// Define MEM_ACCESS_COUNT_EN to add saturating rd_count / wr_count transaction counters.
module mem_access_ctrl #(
   parameter int WORD_SIZE = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 i_req,
   input  logic [WORD_SIZE-1:0] i_addr,
   output logic                 i_ready,
   output logic                 i_valid,
   output logic [WORD_SIZE-1:0] i_rdata,
   input  logic                 d_req,
   input  logic                 d_we,
   input  logic [WORD_SIZE-1:0] d_addr,
   input  logic [WORD_SIZE-1:0] d_wdata,
   output logic                 d_ready,
   output logic                 d_valid,
   output logic [WORD_SIZE-1:0] d_rdata,
   output logic                 readM,
   output logic                 writeM,
   output logic [WORD_SIZE-1:0] address,
   inout  wire  [WORD_SIZE-1:0] data
`ifdef MEM_ACCESS_COUNT_EN
   ,
   output logic [WORD_SIZE-1:0] rd_count,
   output logic [WORD_SIZE-1:0] wr_count
`endif
);

   typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_CAPT, WR} state_t;
   typedef enum logic {CLIENT_I = 1'b0, CLIENT_D = 1'b1} client_t;

   state_t               state;
   client_t              last_grant;
   client_t              owner;
   logic                 drive;
   logic [WORD_SIZE-1:0] wdata_q;
   logic                 grant_i;
   logic                 grant_d;

   // Grants are combinational but qualified by reset_n so no client sees ready while in reset.
   // NOTE: every signal assigned in always_comb gets a default first, otherwise a latch is inferred.
   always_comb begin
      grant_i = 1'b0;
      grant_d = 1'b0;
      if (reset_n && state == IDLE) begin
         if (i_req && d_req) begin
            grant_d = (last_grant == CLIENT_I);
            grant_i = (last_grant == CLIENT_D);
         end else begin
            grant_i = i_req;
            grant_d = d_req;
         end
      end
   end

   assign i_ready = grant_i;
   assign d_ready = grant_d;

   // drive is a register cleared asynchronously, so reset releases the bus at once.
   assign data = drive ? wdata_q : {WORD_SIZE{1'bz}};

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         last_grant <= CLIENT_I;
         owner      <= CLIENT_I;
         drive      <= 1'b0;
         wdata_q    <= '0;
         readM      <= 1'b0;
         writeM     <= 1'b0;
         address    <= '0;
         i_valid    <= 1'b0;
         d_valid    <= 1'b0;
         i_rdata    <= '0;
         d_rdata    <= '0;
      end else begin
         i_valid <= 1'b0;
         d_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_i || grant_d) begin
                  address    <= grant_d ? d_addr : i_addr;
                  owner      <= grant_d ? CLIENT_D : CLIENT_I;
                  last_grant <= grant_d ? CLIENT_D : CLIENT_I;
                  if (grant_d && d_we) begin
                     wdata_q <= d_wdata;
                     writeM  <= 1'b1;
                     drive   <= 1'b1;
                     state   <= WR;
                  end else begin
                     readM <= 1'b1;
                     state <= RD_ISSUE;
                  end
               end
            end
            RD_ISSUE: state <= RD_CAPT;
            RD_CAPT: begin
               // Memory still drives its registered word here; sample it on this edge.
               readM <= 1'b0;
               if (owner == CLIENT_D) begin
                  d_rdata <= data;
                  d_valid <= 1'b1;
               end else begin
                  i_rdata <= data;
                  i_valid <= 1'b1;
               end
               state <= IDLE;
            end
            WR: begin
               writeM <= 1'b0;
               drive  <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MEM_ACCESS_COUNT_EN
   localparam logic [WORD_SIZE-1:0] ONE = WORD_SIZE'(1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_count <= '0;
         wr_count <= '0;
      end else begin
         if (state == RD_CAPT && rd_count != '1) rd_count <= rd_count + ONE;
         if (state == WR && wr_count != '1) wr_count <= wr_count + ONE;
      end
   end
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural registered-output memory on the shared bus.
// Define MEM_ACCESS_COUNT_EN to also exercise the transaction counters.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        i_req, d_req, d_we;
   logic [15:0] i_addr, d_addr, d_wdata;
   logic        i_ready, i_valid, d_ready, d_valid;
   logic [15:0] i_rdata, d_rdata;
   logic        readM, writeM;
   logic [15:0] address;
   wire  [15:0] data;
`ifdef MEM_ACCESS_COUNT_EN
   logic [15:0] rd_count, wr_count;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   mem_access_ctrl #(.WORD_SIZE(16)) dut (
      .clk(clk), .reset_n(reset_n),
      .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_valid(i_valid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ready(d_ready), .d_valid(d_valid), .d_rdata(d_rdata),
      .readM(readM), .writeM(writeM), .address(address), .data(data)
`ifdef MEM_ACCESS_COUNT_EN
      , .rd_count(rd_count), .wr_count(wr_count)
`endif
   );

   // Memory: output word registered on a readM edge, driven while readM is high.
   logic [15:0] mem [0:255];
   logic [15:0] mem_out;
   assign data = readM ? mem_out : 16'hzzzz;
   always @(posedge clk) begin
      if (readM) mem_out <= mem[address[7:0]];
      if (writeM) mem[address[7:0]] <= data;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic do_read(input bit is_d, input logic [15:0] addr, input logic [15:0] exp,
                          input string tag, output int waited, output bit valid_at_req);
      @(negedge clk);
      if (is_d) begin d_req = 1'b1; d_we = 1'b0; d_addr = addr; end
      else begin i_req = 1'b1; i_addr = addr; end
      #1;
      valid_at_req = i_valid | d_valid;
      waited = 0;
      while (!(is_d ? d_ready : i_ready) && waited < 10) begin
         @(negedge clk); #1; waited++;
      end
      check({tag, "_ready"}, is_d ? d_ready : i_ready, 1);
      @(posedge clk); #1;
      i_req = 1'b0; d_req = 1'b0;
      check({tag, "_issue_readM"}, readM, 1);
      check({tag, "_issue_writeM"}, writeM, 0);
      check({tag, "_issue_addr"}, address, addr);
      @(posedge clk); #1;
      check({tag, "_capt_readM"}, readM, 1);
      check({tag, "_capt_valid"}, is_d ? d_valid : i_valid, 0);
      @(posedge clk); #1;
      check({tag, "_done_readM"}, readM, 0);
      check({tag, "_valid"}, is_d ? d_valid : i_valid, 1);
      check({tag, "_rdata"}, is_d ? d_rdata : i_rdata, exp);
   endtask

   task automatic do_write(input logic [15:0] addr, input logic [15:0] wd, input string tag);
      int waited;
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b1; d_addr = addr; d_wdata = wd;
      #1;
      waited = 0;
      while (!d_ready && waited < 10) begin @(negedge clk); #1; waited++; end
      check({tag, "_ready"}, d_ready, 1);
      @(posedge clk); #1;
      d_req = 1'b0; d_we = 1'b0;
      check({tag, "_writeM"}, writeM, 1);
      check({tag, "_readM"}, readM, 0);
      check({tag, "_addr"}, address, addr);
      check({tag, "_bus"}, data, wd);
      @(posedge clk); #1;
      check({tag, "_writeM_off"}, writeM, 0);
      check({tag, "_no_valid"}, d_valid, 0);
      check({tag, "_mem"}, mem[addr[7:0]], wd);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  w;
      bit  v;
      bit  g [0:7];
      int  n_g;

      for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
      mem[8'h00] = 16'h9023;
      mem[8'h23] = 16'h6000;
      mem[8'h24] = 16'hF01C;
      mem_out = 16'h0000;
      reset_n = 1'b0;
      i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
      i_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0;

      // Reset state, with both requests asserted
      repeat (2) @(negedge clk);
      #1;
      check("rst_i_ready", i_ready, 0);
      check("rst_d_ready", d_ready, 0);
      check("rst_readM", readM, 0);
      check("rst_writeM", writeM, 0);
      check("rst_address", address, 16'h0);
      check("rst_valids", {i_valid, d_valid}, 2'b00);
      check("rst_rdata", {i_rdata, d_rdata}, 32'h0);
      @(negedge clk);
      i_req = 1'b0; d_req = 1'b0;
      reset_n = 1'b1;

      // First fetch
      do_read(0, 16'h0000, 16'h9023, "fetch0", w, v);
      check("fetch0_wait", w, 0);
      @(posedge clk); #1;
      check("fetch0_pulse_end", i_valid, 0);

      // Store then load back
      do_write(16'h00F0, 16'hBEEF, "st");
      do_read(1, 16'h00F0, 16'hBEEF, "ld", w, v);
      check("ld_i_quiet", i_valid, 0);

      // Back-to-back fetches
      do_read(0, 16'h0023, 16'h6000, "bb1", w, v);
      do_read(0, 16'h0024, 16'hF01C, "bb2", w, v);
      check("bb2_wait", w, 0);
      check("bb2_overlap_valid", v, 1);

      // Reset during RD_CAPT
      @(negedge clk);
      i_req = 1'b1; i_addr = 16'h0024;
      #1;
      check("abort_ready", i_ready, 1);
      @(posedge clk); #1;
      i_req = 1'b0;
      @(posedge clk); #1;
      check("abort_capt_readM", readM, 1);
      #2 reset_n = 1'b0;
      #1;
      check("abort_readM", readM, 0);
      check("abort_writeM", writeM, 0);
      check("abort_addr", address, 16'h0);
      @(posedge clk); #1;
      check("abort_no_valid", i_valid, 0);
      check("abort_rdata", i_rdata, 16'h0);
      @(negedge clk);
      reset_n = 1'b1;
      do_read(0, 16'h0000, 16'h9023, "post_rst", w, v);

      // Contention: last grant was fetch, so data wins first
      @(negedge clk);
      i_req = 1'b1; i_addr = 16'h0023;
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h00F0;
      n_g = 0;
      for (int c = 0; c < 13; c++) begin
         #1;
         check("cont_exclusive", i_ready & d_ready, 0);
         if ((i_ready | d_ready) && n_g < 8) begin
            g[n_g] = d_ready;
            n_g++;
         end
         @(negedge clk);
      end
      i_req = 1'b0; d_req = 1'b0;
      check("cont_n_grants", n_g, 5);
      check("cont_g0_d", g[0], 1);
      check("cont_g1_i", g[1], 0);
      check("cont_g2_d", g[2], 1);
      check("cont_g3_i", g[3], 0);
      check("cont_g4_d", g[4], 1);
      repeat (4) @(posedge clk);
      #1;
      check("cont_d_rdata", d_rdata, 16'hBEEF);
      check("cont_i_rdata", i_rdata, 16'h6000);

`ifdef MEM_ACCESS_COUNT_EN
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("cnt_rst", {rd_count, wr_count}, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      do_read(1, 16'h0023, 16'h6000, "cl1", w, v);
      do_write(16'h0010, 16'h1111, "cs1");
      do_read(1, 16'h0010, 16'h1111, "cl2", w, v);
      do_write(16'h0011, 16'h2222, "cs2");
      do_read(0, 16'h0024, 16'hF01C, "cl3", w, v);
      check("cnt_rd", rd_count, 16'd3);
      check("cnt_wr", wr_count, 16'd2);
      @(negedge clk);
      force dut.rd_count = 16'hFFFF;
      #1 release dut.rd_count;
      do_read(1, 16'h0011, 16'h2222, "cl4", w, v);
      check("cnt_rd_sat", rd_count, 16'hFFFF);
      check("cnt_wr_hold", wr_count, 16'd2);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Two-client memory access controller for the 16-bit multi-cycle CPU. It arbitrates between the instruction-fetch path and the load/store path and drives the word-addressed `Memory` block's `readM`/`writeM`/`address` controls and its shared tri-state `data` bus. It returns read data to the winning client with a valid pulse. It sits directly upstream of the memory and is the only driver of its control pins.

## Interface
Parameters:
- `WORD_SIZE`, 16, width of addresses and data words

Ports:
- `clk`  in  1  system clock, all state updates on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `i_req`  in  1  instruction fetch request, held until `i_ready`
- `i_addr`  in  WORD_SIZE  fetch address, stable while `i_req`
- `i_ready`  out  1  fetch request accepted this cycle
- `i_valid`  out  1  one-cycle pulse, `i_rdata` valid
- `i_rdata`  out  WORD_SIZE  fetched word
- `d_req`  in  1  data request, held until `d_ready`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  WORD_SIZE  data address
- `d_wdata`  in  WORD_SIZE  store data
- `d_ready`  out  1  data request accepted this cycle
- `d_valid`  out  1  one-cycle pulse, `d_rdata` valid (loads only)
- `d_rdata`  out  WORD_SIZE  loaded word
- `readM`  out  1  memory read strobe
- `writeM`  out  1  memory write strobe
- `address`  out  WORD_SIZE  memory address
- `data`  inout  WORD_SIZE  shared bus; driven only while `writeM`=1, else `'bz`

## Operation
- States: IDLE, RD_ISSUE, RD_CAPT, WR.
- IDLE: requests are granted only in IDLE. `i_ready`/`d_ready` are combinational: the grant is asserted in IDLE for the arbitration winner.
  - Only one request pending: that request wins.
  - Both pending: round-robin. The winner is the client not granted last. `last_grant` resets to "instruction", so the first contention goes to data.
- Acceptance at a clock edge latches the address, the client id and, for a store, the write data.
  - Load or fetch goes to RD_ISSUE.
  - Store goes to WR.
- RD_ISSUE: `readM`=1, `address`=latched address. The memory registers its output at the end of this cycle. Next state is RD_CAPT.
- RD_CAPT: `readM` stays 1, so the memory keeps driving `data`. At the end of the cycle `data` is captured into `i_rdata` or `d_rdata`, and the matching valid pulses for the next cycle. Next state is IDLE.
- WR: `writeM`=1, `readM`=0, `data` driven with the latched store data for the whole cycle. Next state is IDLE. Stores produce no valid pulse.
- `readM` and `writeM` are never both 1. The controller never drives `data` while `readM`=1.
- `*_rdata` holds its last captured value until the next capture.

## Timing
- Reset (asynchronous, immediate) sets:
  - state = IDLE, `last_grant` = instruction
  - `readM`=0, `writeM`=0, `address`=0, `data`='bz
  - `i_ready`=`d_ready`=0 while `reset_n`=0
  - `i_valid`=`d_valid`=0, `i_rdata`=`d_rdata`=0
- Read latency: accept at edge E0 → `readM`/`address` valid during E0–E1 → capture at E2 → valid high during E2–E3.
- A new request can be accepted in the same cycle its predecessor's valid pulse is high. Read throughput is 1 per 3 cycles.
- Store: accept at E0, `writeM` high during E0–E1, and memory updated at E1. Write throughput is 1 per 2 cycles.
- `readM`, `writeM`, `address` and the data-bus drive are all registered outputs, with no combinational path from requests.
- If a request drops before acceptance, nothing happens. Dropping a request after acceptance does not cancel the transaction.
- If reset asserts mid-transaction, the transaction is aborted, no valid pulse is produced, and the bus is released immediately.

## Configuration
- `MEM_ACCESS_COUNT_EN` defined adds output ports `rd_count` and `wr_count` (WORD_SIZE each).
  - `rd_count` increments on every RD_CAPT and `wr_count` on every WR.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters are absent. Core behaviour is identical either way.

## Test plan
- Reset, then `i_req` with `i_addr`=0x0000, memory preloaded with 0x9023 → `i_ready` in the same cycle; `i_valid` high exactly 3 cycles later with `i_rdata`=0x9023; `readM` high for exactly 2 cycles.
- Store `d_addr`=0x00F0, `d_wdata`=0xBEEF, then load 0x00F0 → `writeM` high 1 cycle with `data`=0xBEEF; load returns `d_rdata`=0xBEEF.
- `i_req` and `d_req` held high continuously (loads) → grants alternate D, I, D, I; no client waits more than one transaction.
- Back-to-back fetches 0x0023, 0x0024 → second `i_ready` in the cycle of first `i_valid`; `i_rdata` 0x6000 then 0xF01C.
- Assert `reset_n`=0 during RD_CAPT → `readM`=0 and `data`='bz immediately; no `i_valid`; a subsequent fetch completes normally.
- With `MEM_ACCESS_COUNT_EN`, run 3 loads and 2 stores → `rd_count`=3, `wr_count`=2; force `rd_count` to 0xFFFF, then one more load → still 0xFFFF.
